alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Parametrised, multi-cycle successor to the single-bit ALU slice.
- Computes a WIDTH-bit ALU operation DIGIT bits per clock, reusing one DIGIT-wide slice across cycles.
- Uses the existing control set (invA, enA, enB, Cin, f1/f0) plus a start/ready/done handshake, abort, and result flags.
- Sits between the datapath register file and the result bus; trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- DIGIT, 1, bits processed per clock; WIDTH % DIGIT == 0 required (elaboration error otherwise).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted on an edge where start=1 and ready=1
- abort  in  1  synchronous cancel of an operation in progress
- ready  out  1  block can accept start (state != RUN)
- busy  out  1  operation in progress (state == RUN)
- done  out  1  one-cycle pulse, result/flags just updated
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- invA  in  1  invert effective A
- enA  in  1  enable A
- enB  in  1  enable B
- Cin  in  1  carry-in (ADD only)
- f1, f0  in  1 each  function select
- result  out  WIDTH  registered result
- Cout  out  1  carry out of MSB (ADD), else 0
- zero  out  1  result == 0
- ovf  out  1  signed overflow (ADD), else 0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; result=0, Cout=0, zero=0, ovf=0, done=0, busy=0, ready=1; all internal shift/count/carry registers cleared. Reset mid-RUN discards the operation, and no done is produced.
- Effective operands: Ae = invA XOR (A AND enA), bitwise; Be = B AND enB.
- Function select {f1,f0}: 00 Ae AND Be; 01 Ae OR Be; 10 NOT Be; 11 Ae + Be + Cin.
- Logic ops ignore Cin and force Cout=0, ovf=0.
- Accept (edge T): latch Ae, Be, function, Cin into internal regs; count=0; state IDLE/DONE -> RUN. Input changes after T have no effect.
- RUN, N = WIDTH/DIGIT cycles (edges T+1..T+N):
  - Each edge processes the low DIGIT bits of the operand shift regs and shifts them right by DIGIT.
  - The result digit shifts into the top of the internal result reg; the carry reg takes the slice carry-out.
- Completion (edge T+N): result, Cout, ovf, zero are loaded in the same edge; state RUN -> DONE.
  - Outputs change only at this edge and hold until the next completion or reset.
- done=1 exactly in the cycle after edge T+N (state DONE). Total latency start-accept to done = N cycles.
- ADD flags: Cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The carry into the MSB is captured during the final digit.
- ready = (state != RUN); busy = (state == RUN).
- start while busy is ignored (not queued). start in DONE is accepted, giving back-to-back operations with no idle cycle.
- abort=1 in RUN: next edge -> IDLE, no done, outputs retain previous values. abort outside RUN has no effect. abort and start on the same edge: abort has priority in RUN; start wins in IDLE/DONE.
- DONE -> IDLE after one cycle if no start.

Decomposition:
- Package alu_serial_pkg: function-select constants (FN_AND=2'b00, FN_OR=2'b01, FN_NOTB=2'b10, FN_ADD=2'b11); state encoding IDLE/RUN/DONE.
- Sub-module alu_digit (parametrised DIGIT), purely combinational: inputs a, b, cin, fn; outputs y, cout, and carry into its top bit (for ovf).
- Top level holds the FSM, counter, shift registers, and output registers.

Test Plan:
1. WIDTH=8, DIGIT=1, ADD, enA=enB=1, A=8'h7F, B=8'h01, Cin=0 -> done 8 cycles after accept; result=8'h80, Cout=0, ovf=1, zero=0.
2. ADD, invA=1, enA=enB=1, Cin=1, A=8'h05, B=8'h0C -> result=8'h07, Cout=1, ovf=0 (B-A).
3. A=8'hF0, B=8'h3C: AND -> 8'h30; OR -> 8'hFC; NOT B with enB=0 -> 8'hFF; NOT B with enB=1 -> 8'hC3. Cout=ovf=0 in all four. Issued back-to-back via start in DONE, with no idle cycle between.
4. ADD with A=8'hFF, B=8'h01 -> result=8'h00, zero=1, Cout=1, ovf=0. Then ADD with enA=enB=0, invA=1, Cin=1 -> result=8'h00, Cout=1, zero=1.
5. Abort in the 3rd RUN cycle -> no done pulse, result still 8'h00 from the previous op, ready=1 next cycle. A start pulsed while busy is ignored: exactly one done per accepted start.
6. rst_n low mid-RUN (cycle 4) -> all outputs 0 and ready=1 asynchronously. Repeat test 1 with DIGIT=4 -> done 2 cycles after accept, same result and flags.

Source files
------------

// File: rtl/alu_serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_serial_pkg                                            |
// | Brief    : Shared function-select codes and FSM state encoding for   |
// |            the digit-serial ALU.                                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_serial_pkg;

  // Function select {f1,f0}
  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_NOTB = 2'b10;
  localparam logic [1:0] FN_ADD  = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_serial_if                                             |
// | Brief    : Control, operand and result bundle of the serial ALU.     |
// |            master = requester side, slave = ALU side.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface alu_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             invA;
  logic             enA;
  logic             enB;
  logic             Cin;
  logic             f1;
  logic             f0;
  logic [WIDTH-1:0] result;
  logic             Cout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, abort, A, B, invA, enA, enB, Cin, f1, f0,
    input  ready, busy, done, result, Cout, zero, ovf
  );

  modport slave (
    input  start, abort, A, B, invA, enA, enB, Cin, f1, f0,
    output ready, busy, done, result, Cout, zero, ovf
  );
endinterface
`default_nettype wire

// File: rtl/alu_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_digit                                                 |
// | Brief    : Combinational DIGIT-bit ALU slice. Also reports the carry |
// |            into its top bit so the caller can form signed overflow.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_digit
  import alu_serial_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [1:0]       fn,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0]   carry;
  logic [DIGIT-1:0] sum;

  // Ripple-carry adder across the slice
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  // Function mux; logic ops never report a carry
  always_comb begin
    y    = '0;
    cout = 1'b0;
    cmsb = 1'b0;
    unique case (fn)
      FN_AND:  y = a & b;
      FN_OR:   y = a | b;
      FN_NOTB: y = ~b;
      default: begin
        y    = sum;
        cout = carry[DIGIT];
        cmsb = carry[DIGIT-1];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_serial                                                |
// | Brief    : WIDTH-bit ALU computed DIGIT bits per clock through one   |
// |            shared slice, with start/ready/done handshake and abort.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_serial_if.slave  bus
);

  localparam int            N    = WIDTH / DIGIT;
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("alu_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [1:0]       fn_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;

  logic [WIDTH-1:0] ae;
  logic [WIDTH-1:0] be;
  logic [DIGIT-1:0] y;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] res_next;

  assign ae = {WIDTH{bus.invA}} ^ (bus.A & {WIDTH{bus.enA}});
  assign be = bus.B & {WIDTH{bus.enB}};

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry_q),
    .fn   (fn_q),
    .y    (y),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  // New digit enters at the top; after N steps the first digit sits at bit 0
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(y) << (WIDTH - DIGIT));

  // Sequencer, operand/result shifters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      fn_q     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            a_sh    <= a_sh >> DIGIT;
            b_sh    <= b_sh >> DIGIT;
            res_sh  <= res_next;
            carry_q <= d_cout;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST) begin
              result_q <= res_next;
              cout_q   <= d_cout;
              ovf_q    <= d_cout ^ d_cmsb;
              zero_q   <= (res_next == '0);
              state    <= DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept; start outranks abort here
          if (bus.start) begin
            a_sh    <= ae;
            b_sh    <= be;
            fn_q    <= {bus.f1, bus.f0};
            carry_q <= bus.Cin;
            res_sh  <= '0;
            cnt     <= '0;
            state   <= RUN;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.Cout   = cout_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_serial                                             |
// | Brief    : Self-checking bench for alu_serial (DIGIT=1 and DIGIT=4). |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_serial;
  import alu_serial_pkg::*;

  localparam int W  = 8;
  localparam int N1 = 8;
  localparam int N4 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(W)) bus1 ();
  alu_serial_if #(.WIDTH(W)) bus4 ();

  alu_serial #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  alu_serial #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    logic [7:0] a, b;
    logic       inv, ena, enb, cin;
    logic [1:0] fn;
    logic [7:0] res;
    logic       cout, zero, ovf;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       cout, zero, ovf;
    int         due;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[9];
  int   checks = 0, failures = 0, cyc = 0, n_push = 0, n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [7:0] a, logic [7:0] b, logic inv, logic ena, logic enb,
                              logic cin, logic [1:0] fn, logic [7:0] res, logic cout,
                              logic zero, logic ovf, string name);
    vec_t v;
    v.a = a; v.b = b; v.inv = inv; v.ena = ena; v.enb = enb; v.cin = cin; v.fn = fn;
    v.res = res; v.cout = cout; v.zero = zero; v.ovf = ovf; v.name = name;
    return v;
  endfunction

  // Scoreboard: every done pulse of dut1 is matched against the oldest pending op
  always @(negedge clk) begin
    if (rst_n && bus1.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"},  32'(bus1.result), 32'(mon_e.res));
        check({mon_e.name, "_cout"},    32'(bus1.Cout),   32'(mon_e.cout));
        check({mon_e.name, "_zero"},    32'(bus1.zero),   32'(mon_e.zero));
        check({mon_e.name, "_ovf"},     32'(bus1.ovf),    32'(mon_e.ovf));
        check({mon_e.name, "_latency"}, 32'(cyc),         32'(mon_e.due));
      end
    end
  end

  // Issue one op on dut1 from a negedge; returns at the negedge after the accept edge
  task automatic issue(input vec_t v, input bit expect_done, input bit with_abort,
                       output int acc_cyc);
    int   guard = 0;
    exp_t e;
    while (bus1.ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready=%0b expected 1", bus1.ready);
    end
    bus1.A = v.a; bus1.B = v.b; bus1.invA = v.inv; bus1.enA = v.ena; bus1.enB = v.enb;
    bus1.Cin = v.cin; bus1.f1 = v.fn[1]; bus1.f0 = v.fn[0];
    bus1.abort = with_abort;
    bus1.start = 1'b1;
    acc_cyc = cyc;
    if (expect_done) begin
      e.res = v.res; e.cout = v.cout; e.zero = v.zero; e.ovf = v.ovf;
      e.due = cyc + 1 + N1; e.name = v.name;
      sb.push_back(e);
      n_push++;
    end
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    // Scramble inputs: the latched operation must be unaffected
    bus1.A = 8'($urandom); bus1.B = 8'($urandom);
    bus1.invA = 1'($urandom); bus1.enA = 1'($urandom); bus1.enB = 1'($urandom);
    bus1.Cin = 1'($urandom); bus1.f1 = 1'($urandom); bus1.f0 = 1'($urandom);
  endtask

  initial begin
    int acc, prev_acc, c0, k;

    vt[0] = mk(8'h7F, 8'h01, 0, 1, 1, 0, FN_ADD,  8'h80, 0, 0, 1, "add_7f_01");
    vt[1] = mk(8'h05, 8'h0C, 1, 1, 1, 1, FN_ADD,  8'h07, 1, 0, 0, "sub_0c_05");
    vt[2] = mk(8'hF0, 8'h3C, 0, 1, 1, 1, FN_AND,  8'h30, 0, 0, 0, "and");
    vt[3] = mk(8'hF0, 8'h3C, 0, 1, 1, 1, FN_OR,   8'hFC, 0, 0, 0, "or");
    vt[4] = mk(8'hF0, 8'h3C, 0, 1, 0, 1, FN_NOTB, 8'hFF, 0, 0, 0, "notb_enb0");
    vt[5] = mk(8'hF0, 8'h3C, 0, 1, 1, 1, FN_NOTB, 8'hC3, 0, 0, 0, "notb_enb1");
    vt[6] = mk(8'hFF, 8'h01, 0, 1, 1, 0, FN_ADD,  8'h00, 1, 1, 0, "add_ff_01");
    vt[7] = mk(8'h80, 8'h80, 0, 1, 1, 0, FN_ADD,  8'h00, 1, 1, 1, "add_80_80");
    vt[8] = mk(8'h5A, 8'h33, 1, 0, 0, 1, FN_ADD,  8'h00, 1, 1, 0, "add_dis_inv");

    bus1.start = 0; bus1.abort = 0; bus1.A = 0; bus1.B = 0; bus1.invA = 0;
    bus1.enA = 0; bus1.enB = 0; bus1.Cin = 0; bus1.f1 = 0; bus1.f0 = 0;
    bus4.start = 0; bus4.abort = 0; bus4.A = 0; bus4.B = 0; bus4.invA = 0;
    bus4.enA = 0; bus4.enB = 0; bus4.Cin = 0; bus4.f1 = 0; bus4.f0 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_result", 32'(bus1.result), 0);
    check("rst_flags",  32'({bus1.Cout, bus1.zero, bus1.ovf, bus1.done}), 0);
    check("rst_ready",  32'(bus1.ready), 1);
    check("rst_busy",   32'(bus1.busy), 0);
    check("rst4_ready", 32'(bus4.ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of ops, issued back-to-back through the DONE state
    prev_acc = 0;
    for (int i = 0; i < 9; i++) begin
      issue(vt[i], 1'b1, 1'b0, acc);
      if (i > 0) check({vt[i].name, "_b2b"}, 32'(acc), 32'(prev_acc + 1 + N1));
      prev_acc = acc;
    end

    // Abort in the 3rd RUN cycle, with an ignored start while busy
    issue(vt[0], 1'b0, 1'b0, acc);
    check("abort_busy",  32'(bus1.busy), 1);
    check("abort_ready", 32'(bus1.ready), 0);
    bus1.start = 1'b1; bus1.A = 8'h11; bus1.B = 8'h22;
    @(negedge clk);
    bus1.start = 1'b0;
    @(negedge clk);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    check("abort_ready_after", 32'(bus1.ready), 1);
    check("abort_busy_after",  32'(bus1.busy), 0);
    check("abort_no_done",     32'(bus1.done), 0);
    check("abort_result_kept", 32'(bus1.result), 32'h00);
    repeat (10) @(negedge clk);

    // Start+abort in IDLE: start wins; mid-RUN start pulse ignored
    issue(vt[0], 1'b1, 1'b1, acc);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    repeat (12) @(negedge clk);
    check("one_done_per_start", 32'(n_done), 32'(n_push));

    // Asynchronous reset in the 4th RUN cycle
    issue(vt[1], 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 32'(bus1.result), 0);
    check("arst_flags",  32'({bus1.Cout, bus1.zero, bus1.ovf, bus1.done}), 0);
    check("arst_ready",  32'(bus1.ready), 1);
    check("arst_busy",   32'(bus1.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // DIGIT=4 instance: add 7F+01
    bus4.A = 8'h7F; bus4.B = 8'h01; bus4.invA = 0; bus4.enA = 1; bus4.enB = 1;
    bus4.Cin = 0; bus4.f1 = 1; bus4.f0 = 1; bus4.start = 1;
    c0 = cyc;
    @(negedge clk);
    bus4.start = 0; bus4.A = 8'h00; bus4.B = 8'hAA;
    for (k = 0; k < 20 && bus4.done !== 1'b1; k++) @(negedge clk);
    check("d4_latency", 32'(cyc - c0), 32'(1 + N4));
    check("d4_result",  32'(bus4.result), 32'h80);
    check("d4_cout",    32'(bus4.Cout), 0);
    check("d4_ovf",     32'(bus4.ovf), 1);
    check("d4_zero",    32'(bus4.zero), 0);
    @(negedge clk);
    check("d4_done_pulse", 32'(bus4.done), 0);

    check("pending_done", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
